sdq_queue_ctrl: RTL and testbench

- Circular-queue controller that owns the R0/W0 port pair of an external 1R1W store-data-queue array (sdq_17x64-class macro, combinational read, write at clock edge).
- Converts a valid/ready enqueue stream into array writes and array reads into a registered valid/ready dequeue stream.
- Sits between the LSU store-data path and the SDQ macro; the array holds entries, and this block owns pointers, occupancy and the output register.

---
 rtl/sdq_queue_ctrl_pkg.sv | 12 +
 rtl/sdq_ptr_wrap.sv | 21 ++
 rtl/sdq_queue_ctrl.sv | 83 ++++++++
 tb/tb_sdq_queue_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdq_queue_ctrl_pkg.sv
// sdq_queue_ctrl_pkg: shared sizes, pointer/count types and the modulo-DEPTH pointer increment
package sdq_queue_ctrl_pkg;
    localparam int DEPTH_DEF  = 17;
    localparam int WIDTH_DEF  = 64;
    localparam int ADDR_W_DEF = 5;
    // DEPTH never exceeds 31, so 5 pointer bits and 6 count bits always suffice
    typedef logic [ADDR_W_DEF-1:0] ptr_t;
    typedef logic [ADDR_W_DEF:0]   cnt_t;
    function automatic ptr_t ptr_inc(input ptr_t ptr, input int depth);
        return (int'(ptr) == depth - 1) ? '0 : ptr + ptr_t'(1);
    endfunction
endpackage

// File: rtl/sdq_ptr_wrap.sv
// sdq_ptr_wrap: modulo-DEPTH pointer register with synchronous clear and increment
module sdq_ptr_wrap
    import sdq_queue_ctrl_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_inc,
    input  logic              i_clr,
    output logic [ADDR_W-1:0] o_ptr
);
    logic [ADDR_W-1:0] r_ptr;
    always_ff @(posedge clock or posedge reset) begin
        if (reset)      r_ptr <= '0;
        else if (i_clr) r_ptr <= '0;
        else if (i_inc) r_ptr <= ADDR_W'(ptr_inc(ptr_t'(r_ptr), DEPTH));
    end
    assign o_ptr = r_ptr;
endmodule

// File: rtl/sdq_queue_ctrl.sv
// sdq_queue_ctrl: circular-queue controller for a 1R1W SDQ array with a registered dequeue stage.
// Define SDQ_QUEUE_CTRL_BYPASS_EN to load enqueue data straight into the output register when the queue is empty.
module sdq_queue_ctrl
    import sdq_queue_ctrl_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [WIDTH-1:0]  enq_data,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [WIDTH-1:0]  deq_data,
    output logic [ADDR_W-1:0] count,
    output logic [ADDR_W-1:0] W0_addr,
    output logic              W0_en,
    output logic [WIDTH-1:0]  W0_data,
    output logic [ADDR_W-1:0] R0_addr,
    output logic              R0_en,
    input  logic [WIDTH-1:0]  R0_data
);
    cnt_t              r_arr_cnt;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic [ADDR_W-1:0] w_head, w_tail;
    logic              w_enq_fire, w_deq_fire, w_out_free, w_refill, w_bypass, w_write;

    assign enq_ready  = !flush && (r_arr_cnt < cnt_t'(DEPTH));
    assign w_enq_fire = enq_valid && enq_ready;
    assign w_deq_fire = r_out_valid && deq_ready;
    assign w_out_free = !r_out_valid || w_deq_fire;
    assign w_refill   = w_out_free && (r_arr_cnt != '0) && !flush;
`ifdef SDQ_QUEUE_CTRL_BYPASS_EN
    assign w_bypass   = w_out_free && (r_arr_cnt == '0) && w_enq_fire;
`else
    assign w_bypass   = 1'b0;
`endif
    assign w_write    = w_enq_fire && !w_bypass;

    sdq_ptr_wrap #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_head (
        .clock(clock), .reset(reset), .i_inc(w_refill), .i_clr(flush), .o_ptr(w_head)
    );
    sdq_ptr_wrap #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_tail (
        .clock(clock), .reset(reset), .i_inc(w_write), .i_clr(flush), .o_ptr(w_tail)
    );

    // Array-facing outputs are forced low while reset is held
    assign W0_en   = w_write && !reset;
    assign W0_addr = w_tail;
    assign W0_data = reset ? '0 : enq_data;
    assign R0_en   = w_refill && !reset;
    assign R0_addr = w_head;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_arr_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_arr_cnt <= flush ? '0 : r_arr_cnt + cnt_t'(w_write) - cnt_t'(w_refill);
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_refill) begin
                r_out_valid <= 1'b1;
                r_out_data  <= R0_data;
            end else if (w_bypass) begin
                r_out_valid <= 1'b1;
                r_out_data  <= enq_data;
            end else if (w_deq_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign deq_valid = r_out_valid;
    assign deq_data  = r_out_data;
    assign count     = ADDR_W'(r_arr_cnt + cnt_t'(r_out_valid));
endmodule

// File: tb/tb_sdq_queue_ctrl.sv
// tb_sdq_queue_ctrl: directed vectors and corner-case sequences for sdq_queue_ctrl with a behavioural SDQ array.
module tb_sdq_queue_ctrl;
    localparam int D = 17;
    localparam int W = 64;
    localparam int A = 5;
`ifdef SDQ_QUEUE_CTRL_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clock = 1'b0, reset = 1'b0, flush = 1'b0, enq_valid = 1'b0, deq_ready = 1'b0;
    logic         enq_ready, deq_valid, W0_en, R0_en;
    logic [W-1:0] enq_data = '0, deq_data, W0_data, R0_data;
    logic [A-1:0] count, W0_addr, R0_addr;
    logic [W-1:0] mem [0:D-1];
    int           checks = 0, errors = 0;

    typedef struct {
        logic         ev;
        logic [W-1:0] ed;
        logic         dr;
        logic         fl;
        logic         er;
        logic         dv;
        logic [W-1:0] dd;
        logic [A-1:0] cnt;
        logic         wen;
        logic         ren;
    } vec_t;
    vec_t tv [8];

    sdq_queue_ctrl dut (
        .clock(clock), .reset(reset), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data),
        .count(count),
        .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data),
        .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data)
    );

    always #5 clock = ~clock;
    always @(posedge clock) if (W0_en) mem[W0_addr] <= W0_data;
    assign R0_data = (int'(R0_addr) < D) ? mem[R0_addr] : '0;

    function automatic vec_t mk(bit ev, logic [W-1:0] ed, bit dr, bit fl, bit er, bit dv,
                                logic [W-1:0] dd, int cnt, bit wen, bit ren);
        vec_t v;
        v.ev = ev; v.ed = ed; v.dr = dr; v.fl = fl; v.er = er; v.dv = dv;
        v.dd = dd; v.cnt = A'(cnt); v.wen = wen; v.ren = ren;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0; enq_data = '0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int c, acc, nw, sent, got, last_w, last_r;
        bit wrap_w, wrap_r;
        tv[0] = mk(1, 64'hA1, 0, 0, 1, 0,   64'h0,             0, !BYP, 0);
        tv[1] = mk(1, 64'hA2, 0, 0, 1, BYP, BYP ? 64'hA1 : 0,  1, 1,    !BYP);
        tv[2] = mk(0, 64'h0,  0, 0, 1, 1,   64'hA1,            2, 0,    0);
        tv[3] = mk(0, 64'h0,  1, 0, 1, 1,   64'hA1,            2, 0,    1);
        tv[4] = mk(0, 64'h0,  1, 0, 1, 1,   64'hA2,            1, 0,    0);
        tv[5] = mk(0, 64'h0,  0, 0, 1, 0,   64'hA2,            0, 0,    0);
        tv[6] = mk(1, 64'hA3, 0, 1, 0, 0,   64'hA2,            0, 0,    0);
        tv[7] = mk(0, 64'h0,  0, 0, 1, 0,   64'hA2,            0, 0,    0);

        do_reset();
        chk("reset_deq_valid", deq_valid, 0);
        chk("reset_deq_data", deq_data, 0);
        chk("reset_count", count, 0);
        for (int i = 0; i < 8; i++) begin
            enq_valid = tv[i].ev; enq_data = tv[i].ed; deq_ready = tv[i].dr; flush = tv[i].fl;
            #1;
            chk($sformatf("v%0d_enq_ready", i), enq_ready, tv[i].er);
            chk($sformatf("v%0d_deq_valid", i), deq_valid, tv[i].dv);
            chk($sformatf("v%0d_deq_data", i), deq_data, tv[i].dd);
            chk($sformatf("v%0d_count", i), count, tv[i].cnt);
            chk($sformatf("v%0d_W0_en", i), W0_en, tv[i].wen);
            chk($sformatf("v%0d_R0_en", i), R0_en, tv[i].ren);
            tick();
        end
        flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;

        // Fill until enq_ready drops, then dequeue at full
        do_reset();
        enq_valid = 1'b1;
        acc = 0; nw = 0;
        for (int k = 0; k < 40; k++) begin
            enq_data = 64'(k);
            #1;
            if (W0_en) begin
                chk("fill_waddr", W0_addr, 64'(nw % D));
                nw++;
            end
            if (!enq_ready) break;
            acc++;
            tick();
        end
        chk("fill_accepted", acc, 18);
        chk("fill_writes", nw, 18 - int'(BYP));
        chk("fill_count", count, 18);
        chk("fill_enq_ready", enq_ready, 0);
        deq_ready = 1'b1;
        #1;
        chk("full_deq_enq_ready", enq_ready, 0);
        chk("full_deq_W0_en", W0_en, 0);
        tick();
        deq_ready = 1'b0;
        #1;
        chk("after_deq_enq_ready", enq_ready, 1);
        chk("after_deq_count", count, 17);
        enq_valid = 1'b0;

        // Asynchronous reset between edges
        do_reset();
        enq_valid = 1'b1; enq_data = 64'h77;
        #1;
        c = 0;
        while (count != 5 && c < 20) begin
            tick();
            #1;
            c++;
        end
        chk("rst_pre_count", count, 5);
        reset = 1'b1;
        #1;
        chk("rst_deq_valid", deq_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_W0_en", W0_en, 0);
        chk("rst_R0_en", R0_en, 0);
        reset = 1'b0;
        enq_valid = 1'b0;

        // Enqueue-to-deq_valid latency from empty
        do_reset();
        enq_valid = 1'b1; enq_data = 64'hDEAD;
        #1;
        chk("lat_W0_en", W0_en, !BYP);
        tick();
        enq_valid = 1'b0;
        #1;
        chk("lat_c1_deq_valid", deq_valid, BYP);
        tick();
        #1;
        chk("lat_c2_deq_valid", deq_valid, 1);
        chk("lat_c2_deq_data", deq_data, 64'hDEAD);

        // Streaming with pointer wrap and exact order
        do_reset();
        sent = 0; got = 0; last_w = -1; last_r = -1; wrap_w = 0; wrap_r = 0;
        for (int k = 0; k < 200 && got < 40; k++) begin
            enq_valid = (sent < 40);
            enq_data  = 64'h1000 + 64'(sent);
            deq_ready = (k >= 3);
            #1;
            if (deq_valid && deq_ready) begin
                chk("wrap_deq_data", deq_data, 64'h1000 + 64'(got));
                got++;
            end
            if (enq_valid && enq_ready) sent++;
            if (W0_en) begin
                if (last_w == D - 1 && W0_addr == 0) wrap_w = 1;
                last_w = int'(W0_addr);
            end
            if (R0_en) begin
                if (last_r == D - 1 && R0_addr == 0) wrap_r = 1;
                last_r = int'(R0_addr);
            end
            tick();
        end
        chk("wrap_got", got, 40);
        chk("wrap_W0_seen", wrap_w, 1);
        chk("wrap_R0_seen", wrap_r, 1);
        enq_valid = 1'b0; deq_ready = 1'b0;

        // Flush with enqueue and dequeue pending
        do_reset();
        enq_valid = 1'b1; enq_data = 64'h99;
        #1;
        c = 0;
        while (count != 9 && c < 30) begin
            tick();
            #1;
            c++;
        end
        chk("flush_pre_count", count, 9);
        flush = 1'b1; deq_ready = 1'b1;
        #1;
        chk("flush_enq_ready", enq_ready, 0);
        chk("flush_W0_en", W0_en, 0);
        chk("flush_R0_en", R0_en, 0);
        tick();
        flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        #1;
        chk("flush_count", count, 0);
        chk("flush_deq_valid", deq_valid, 0);
        enq_valid = 1'b1; enq_data = 64'h55;
        #1;
        chk("flush_next_W0_addr", W0_addr, 0);
        chk("flush_next_W0_en", W0_en, !BYP);
        tick();
        enq_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
